pool_stride_packer: RTL
=======================

# pool_stride_packer

Downstream stage of the 1-D max-pool layer. Consumes the pool output stream, discards the sliding-window results that fall between strides, and packs the retained pooled values into a wide word. The word is presented to the next layer, or to the feature-map store, through a valid/ready handshake. It tracks window fill and stride phase from the same `ena` strobe that drives the pool layer, so no extra control is needed upstream.

## Interface
- BITWIDTH, 8, width of one pooled value (unsigned)
- LENGTH, 4, pool window length; must match the pool layer
- STRIDE, 4, windows advanced between retained results (≥1)
- POOL_LAT, 1, cycles from an `ena` cycle to its pooled value on `in_max` (≥1)
- PACK, 4, pooled values per output word (≥1)

Ports:
- clk, in, 1, single clock, rising edge
- rstn, in, 1, asynchronous active-low reset
- ena, in, 1, same shift strobe that drives the pool layer
- clr, in, 1, synchronous clear of the framing state
- in_max, in, BITWIDTH, pool layer output
- out_data, out, PACK*BITWIDTH, packed word; lane 0 in the LSBs
- out_valid, out, 1, `out_data` holds an unconsumed word
- out_ready, in, 1, consumer accepts the word
- overflow, out, 1, sticky: a completed word was dropped

## Operation
- Event detection:
  - A POOL_LAT-deep shift register delays `ena`.
  - An event occurs in cycle t when `ena` was high at t−POOL_LAT; `in_max` is sampled in that cycle.
- Fill counter:
  - Counts events from 0 and saturates at LENGTH−1.
  - Event index k (0-based since reset or `clr`) is a complete window when k ≥ LENGTH−1.
- Stride phase counter:
  - Range 0..STRIDE−1. It is forced to 0 on the first complete window and increments modulo STRIDE on each later complete-window event.
  - A window is retained when phase is 0, i.e. when (k−(LENGTH−1)) mod STRIDE == 0.
- Packing:
  - A retained value is written into lane `lane` of the partial word. `lane` is 0..PACK−1 and increments after each write.
  - The write to lane PACK−1 completes the word, and `lane` wraps to 0.
- Word hand-off:
  - A completed word moves to the output register if `out_valid` is 0, or if `out_valid & out_ready` in the same cycle (back-to-back).
  - Otherwise the word is dropped, `overflow` is set, and the output register keeps its old word.
  - The partial word is cleared after every completion.
- Handshake:
  - A transfer occurs when `out_valid & out_ready`.
  - `out_data` is stable while `out_valid` is high and un-accepted.
  - `out_valid` falls the cycle after a transfer unless a new word loads in that same cycle.
- `clr` (synchronous, highest priority):
  - Zeroes the delay line, fill counter, phase, `lane`, partial word and `overflow`.
  - The output register and `out_valid` are kept, so a pending word is still delivered.
  - An event coinciding with `clr` is ignored.
- Reset: every register is 0, including `out_data`, `out_valid`, `overflow` and all counters.

## Timing
- Pool pipeline alignment: an `ena` at cycle t produces an event at t+POOL_LAT.
- Latency: the event cycle that completes a word is e; `out_valid` = 1 and `out_data` are valid from cycle e+1.
- Throughput: one word per cycle is sustained under continuous `out_ready`, given STRIDE=1 and PACK=1.
- `out_valid` is registered only.
- `out_ready` may toggle freely; it never combinationally affects `out_data`.
- Reset mid-operation: an asynchronous assert immediately zeroes all outputs, and any partial word is lost.
- `ena` gaps: counters simply pause; phase and lane are kept across gaps.

## Test plan
Default parameters unless stated. t0 is the first `ena` cycle, and event k occurs at t0+k+1.
- Basic framing:
  - Stimulus: `ena` high for 20 cycles; `in_max` = k at event k; `out_ready`=1.
  - Required: exactly one word, 0x0F0B0703, with `out_valid` at t0+17 only.
- Backpressure hold:
  - Stimulus: same as basic framing, but `out_ready`=0 until t0+25.
  - Required: `out_valid` high from t0+17 to t0+25 with `out_data` constant; it falls at t0+26.
- Overflow:
  - Stimulus: STRIDE=1, PACK=1, `out_ready`=0, `ena` continuous with `in_max`=k.
  - Required: the first word is 0x03 and is held. `overflow`=1 from the cycle after the event k=4 drop, and the word stays 0x03.
  - Then assert `clr` → `overflow`=0 and `out_valid` stays 1.
- Back-to-back:
  - Stimulus: STRIDE=1, PACK=1, `out_ready`=1, `ena` continuous.
  - Required: `out_valid` stays high every cycle from t0+5; `out_data` steps 3,4,5,… and `overflow` stays 0.
- `clr` mid-word:
  - Stimulus: `clr` pulsed at t0+10 (event 9), with `ena` continuing.
  - Required: the count restarts, and the next retained values are events at cycles t0+11+3, +7, +11 and +15 relative to the new origin. No word mixes pre-clr lanes.
- Async reset mid-word:
  - Stimulus: `rstn` low at t0+12.
  - Required: `out_valid`, `out_data` and `overflow` are 0 immediately; after release the framing restarts exactly as in basic framing.

Source files
------------

// File: rtl/pool_stride_packer.sv
// Strided packer behind the 1-D max-pool layer: keeps every STRIDE-th complete
// window and packs PACK retained values into one word on a valid/ready output.
module pool_stride_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         wr,
  input  logic [W-1:0] d,
  output logic [W-1:0] nxt
);
  logic [W-1:0] q;

  // nxt lets the completing write bypass into the output word in the same cycle
  assign nxt = wr ? d : q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    q <= '0;
    else if (clr) q <= '0;
    else if (wr)  q <= d;
  end
endmodule

module pool_stride_packer #(
  parameter int BITWIDTH = 8,
  parameter int LENGTH   = 4,
  parameter int STRIDE   = 4,
  parameter int POOL_LAT = 1,
  parameter int PACK     = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     ena,
  input  logic                     clr,
  input  logic [BITWIDTH-1:0]      in_max,
  output logic [PACK*BITWIDTH-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overflow
);
  localparam int FW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int LW = (PACK > 1)   ? $clog2(PACK)   : 1;

  logic [POOL_LAT-1:0]               dly;
  logic [FW-1:0]                     fill;
  logic [PW-1:0]                     phase;
  logic [LW-1:0]                     lane;
  logic                              evt, complete, keep, done, load;
  logic [PACK-1:0]                   lane_wr;
  logic [PACK-1:0][BITWIDTH-1:0]     nxt_w;

  // an event landing in a clr cycle belongs to the discarded framing
  assign evt      = dly[POOL_LAT-1] & ~clr;
  assign complete = (fill == FW'(LENGTH-1));
  assign keep     = evt & complete & (phase == '0);
  assign done     = keep & (lane == LW'(PACK-1));
  assign load     = done & (~out_valid | out_ready);

  for (genvar g = 0; g < PACK; g++) begin : g_lane
    assign lane_wr[g] = keep & (lane == LW'(g));
    pool_stride_lane #(.W(BITWIDTH)) u_lane (
      .clk  (clk),
      .rstn (rstn),
      .clr  (clr | done),
      .wr   (lane_wr[g]),
      .d    (in_max),
      .nxt  (nxt_w[g])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dly <= '0;
    end else if (clr) begin
      dly <= '0;
    end else begin
      dly[0] <= ena;
      for (int i = 1; i < POOL_LAT; i++) dly[i] <= dly[i-1];
    end
  end

  // phase needs no first-window special case: it is 0 until the first complete event
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fill     <= '0;
      phase    <= '0;
      lane     <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      fill     <= '0;
      phase    <= '0;
      lane     <= '0;
      overflow <= 1'b0;
    end else begin
      if (evt && !complete) fill <= fill + FW'(1);
      if (evt && complete)
        phase <= (phase == PW'(STRIDE-1)) ? '0 : phase + PW'(1);
      if (keep) lane <= done ? '0 : lane + LW'(1);
      if (done && !load) overflow <= 1'b1;
    end
  end

  // output register is outside the clr domain so a pending word still drains
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= nxt_w;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
